// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the program ROM address and
// loads the returned instruction into the IF/ID register; halts on a bad fetch address.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal fetch: sequential, redirect, stall and flush handling
// HALT  | bad next PC seen; PC and fault info frozen, IF/ID loads bubbles
module instruction_fetch_stage #(
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
   parameter int                    MEMORY_DEPTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Stall,
   input  logic                  Flush,
   input  logic                  BranchTaken,
   input  logic [DATA_WIDTH-1:0] BranchTarget,
   input  logic                  Jump,
   input  logic [DATA_WIDTH-1:0] JumpTarget,
   input  logic [DATA_WIDTH-1:0] Instruction,
   output logic [DATA_WIDTH-1:0] PC,
   output logic [DATA_WIDTH-1:0] IFID_Instruction,
   output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
   output logic                  IFID_Valid,
   output logic                  Fault,
   output logic [DATA_WIDTH-1:0] FaultAddr,
   output logic [DATA_WIDTH-1:0] FetchCount
);

   localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] CNT_STEP = DATA_WIDTH'(1);
   // First byte address past the end of program memory (exclusive bound).
   localparam logic [DATA_WIDTH-1:0] PC_END   = RESET_PC + DATA_WIDTH'(4 * MEMORY_DEPTH);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   pc_plus4;
   logic [DATA_WIDTH-1:0]   next_pc;
   logic                    next_bad;
   logic                    redirect;

   always_comb begin
      pc_plus4 = PC + PC_STEP;
      redirect = Jump | BranchTaken;
      next_pc  = pc_plus4;
      if (Jump)
         next_pc = JumpTarget;
      else if (BranchTaken)
         next_pc = BranchTarget;
      else if (Stall)
         next_pc = PC;
      // A PC+4 wrap past 2^DATA_WIDTH lands below RESET_PC and is caught here.
      next_bad = (next_pc[1:0] != 2'b00) || (next_pc < RESET_PC) || (next_pc >= PC_END);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_RUN;
         PC               <= RESET_PC;
         IFID_Instruction <= '0;
         IFID_PCPlus4     <= '0;
         IFID_Valid       <= 1'b0;
         Fault            <= 1'b0;
         FaultAddr        <= '0;
         FetchCount       <= '0;
      end else if (state == ST_RUN) begin
         if (next_bad) begin
            state     <= ST_HALT;
            Fault     <= 1'b1;
            FaultAddr <= next_pc;
         end else begin
            PC <= next_pc;
         end

         if (redirect || Flush) begin
            IFID_Instruction <= '0;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
         end else if (!Stall) begin
            IFID_Instruction <= Instruction;
            IFID_PCPlus4     <= pc_plus4;
            IFID_Valid       <= 1'b1;
            FetchCount       <= FetchCount + CNT_STEP;
         end
      end else begin
         IFID_Instruction <= '0;
         IFID_PCPlus4     <= '0;
         IFID_Valid       <= 1'b0;
      end
   end

endmodule
